// File: rtl/rob_ctrl.sv
// rob_ctrl: ROB head/tail/done-bit bookkeeping with all-or-nothing allocation and in-order commit.
// Define ROB_CTRL_STAT_EN to add the stall_cycles/retired statistics counters.
module rob_ctrl #(
  parameter int ROB_DEPTH     = 16,
  parameter int MACHINE_WIDTH = 2,
  parameter int FU_NUM        = 4,
  parameter int AW            = $clog2(ROB_DEPTH)
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [MACHINE_WIDTH-1:0]    alloc_req,
  output logic                        alloc_ok,
  output logic [MACHINE_WIDTH*AW-1:0] rob_addr,
  input  logic [FU_NUM-1:0]           wb_valid,
  input  logic [FU_NUM*AW-1:0]        wb_addr,
  output logic [MACHINE_WIDTH-1:0]    commit_valid,
  output logic [MACHINE_WIDTH*AW-1:0] commit_addr,
  input  logic                        commit_ready,
  input  logic                        flush,
  output logic [AW:0]                 count,
  output logic                        full,
  output logic                        empty
`ifdef ROB_CTRL_STAT_EN
  ,
  output logic [31:0]                 stall_cycles,
  output logic [31:0]                 retired
`endif
);
  logic [AW:0] head_q, head_d, tail_q, tail_d, count_q, count_d;
  logic [AW:0] n_req, n_com, n_alloc;
  logic [ROB_DEPTH-1:0] done_q, done_d;
  logic [AW-1:0] idx;
  logic run;
  always_comb begin
    n_req = '0;
    n_com = '0;
    idx = '0;
    run = !flush;
    rob_addr = '0;
    commit_addr = '0;
    commit_valid = '0;
    for (int i = 0; i < MACHINE_WIDTH; i++) begin
      idx = head_q[AW-1:0] + AW'(i);
      run = run && (count_q > (AW+1)'(i)) && done_q[idx];
      commit_valid[i] = run;
      commit_addr[i*AW +: AW] = idx;
      rob_addr[i*AW +: AW] = tail_q[AW-1:0] + AW'(i);
      n_req = n_req + (AW+1)'(alloc_req[i]);
      n_com = n_com + (AW+1)'(run && commit_ready);
    end
    // free space is judged on registered count only; same-cycle retirement is not reused
    alloc_ok = !flush && (((AW+1)'(ROB_DEPTH) - count_q) >= n_req);
    n_alloc = alloc_ok ? n_req : '0;
    done_d = done_q;
    for (int k = 0; k < FU_NUM; k++)
      if (wb_valid[k]) done_d[wb_addr[k*AW +: AW]] = 1'b1;
    for (int i = 0; i < MACHINE_WIDTH; i++)
      if (alloc_ok && alloc_req[i]) done_d[tail_q[AW-1:0] + AW'(i)] = 1'b0;
    done_d = flush ? '0 : done_d;
    head_d = flush ? '0 : head_q + n_com;
    tail_d = flush ? '0 : tail_q + n_alloc;
    count_d = flush ? '0 : count_q + n_alloc - n_com;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      done_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      done_q <= done_d;
    end
  end
  assign count = count_q;
  assign full = count_q == (AW+1)'(ROB_DEPTH);
  assign empty = count_q == '0;
`ifdef ROB_CTRL_STAT_EN
  logic [31:0] stall_q, stall_d, retired_q, retired_d;
  always_comb begin
    stall_d = stall_q + 32'((alloc_req != '0) && !alloc_ok && !flush);
    retired_d = retired_q + 32'(n_com);
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      stall_q <= '0;
      retired_q <= '0;
    end else begin
      stall_q <= stall_d;
      retired_q <= retired_d;
    end
  end
  assign stall_cycles = stall_q;
  assign retired = retired_q;
`endif
endmodule

// File: tb/tb_rob_ctrl.sv
// tb_rob_ctrl: randomized scoreboard bench; the model keeps in-flight entries as an ordered queue of done flags.
module tb_rob_ctrl;
  localparam int D = 16, MW = 2, FU = 4, AW = 4;
  logic clk = 0, resetn = 0, commit_ready = 0, flush = 0;
  logic alloc_ok, full, empty;
  logic [MW-1:0] alloc_req = '0, commit_valid;
  logic [MW*AW-1:0] rob_addr, commit_addr;
  logic [FU-1:0] wb_valid = '0;
  logic [FU*AW-1:0] wb_addr = '0;
  logic [AW:0] count;
`ifdef ROB_CTRL_STAT_EN
  logic [31:0] stall_cycles, retired;
  int m_stall = 0, m_retired = 0;
`endif
  rob_ctrl dut (
    .clk(clk), .resetn(resetn), .alloc_req(alloc_req), .alloc_ok(alloc_ok), .rob_addr(rob_addr),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .commit_valid(commit_valid), .commit_addr(commit_addr),
    .commit_ready(commit_ready), .flush(flush), .count(count), .full(full), .empty(empty)
`ifdef ROB_CTRL_STAT_EN
    , .stall_cycles(stall_cycles), .retired(retired)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {
    logic ok;
    logic [MW*AW-1:0] ra;
    logic [MW-1:0] cv;
    logic [MW*AW-1:0] ca;
    int cnt;
  } exp_t;
  exp_t exp_q[$];
  int checks = 0, errors = 0;
  int head = 0;
  bit done_m[$];
  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, x, $time);
    end
  endtask
  initial forever begin
    @(negedge clk);
    #3;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("alloc_ok", 64'(alloc_ok), 64'(e.ok));
      chk("rob_addr", 64'(rob_addr), 64'(e.ra));
      chk("commit_valid", 64'(commit_valid), 64'(e.cv));
      chk("commit_addr", 64'(commit_addr), 64'(e.ca));
      chk("count", 64'(count), 64'(e.cnt));
      chk("full", 64'(full), 64'(e.cnt == D));
      chk("empty", 64'(empty), 64'(e.cnt == 0));
    end
  end
  task automatic step(input logic [MW-1:0] ar, input logic [FU-1:0] wv, input logic cr, input logic fl);
    exp_t e;
    int n, ncv, sz;
    int wbj[FU];
    @(negedge clk);
    #1;
    sz = done_m.size();
    n = int'(ar[0]) + int'(ar[1]);
    e.cnt = sz;
    e.ok = !fl && (D - sz >= n);
    ncv = 0;
    while (!fl && ncv < MW && ncv < sz && done_m[ncv]) ncv++;
    e.cv = MW'((1 << ncv) - 1);
    for (int i = 0; i < MW; i++) begin
      e.ra[i*AW +: AW] = AW'((head + sz + i) % D);
      e.ca[i*AW +: AW] = AW'((head + i) % D);
    end
    for (int k = 0; k < FU; k++) begin
      wbj[k] = 0;
      if (wv[k] && sz > 0) begin
        wbj[k] = $urandom_range(0, sz - 1);
        wb_addr[k*AW +: AW] = AW'((head + wbj[k]) % D);
      end else wv[k] = 1'b0;
    end
    alloc_req = ar;
    wb_valid = wv;
    commit_ready = cr;
    flush = fl;
    exp_q.push_back(e);
`ifdef ROB_CTRL_STAT_EN
    if (ar != '0 && !e.ok && !fl) m_stall++;
    if (cr) m_retired += ncv;
`endif
    if (fl) begin
      done_m.delete();
      head = 0;
    end else begin
      for (int k = 0; k < FU; k++) if (wv[k]) done_m[wbj[k]] = 1'b1;
      if (cr) repeat (ncv) begin
        void'(done_m.pop_front());
        head = (head + 1) % D;
      end
      if (e.ok) repeat (n) done_m.push_back(1'b0);
    end
  endtask
  task automatic rst_cycle();
    @(negedge clk);
    #1;
    resetn = 0;
    alloc_req = '0;
    wb_valid = '0;
    commit_ready = 0;
    flush = 0;
    @(posedge clk);
    #1;
    resetn = 1;
    done_m.delete();
    head = 0;
`ifdef ROB_CTRL_STAT_EN
    m_stall = 0;
    m_retired = 0;
`endif
  endtask
  initial begin
    logic [MW-1:0] ar;
    logic [FU-1:0] wv;
    int cr_pct;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1;
    repeat (8) step(2'b11, '0, 1'b0, 1'b0);
    step(2'b01, '0, 1'b0, 1'b0);
    step(2'b01, 4'b1111, 1'b0, 1'b0);
    repeat (3) step(2'b11, 4'b0011, 1'b1, 1'b0);
    step(2'b11, 4'b0001, 1'b1, 1'b1);
    step(2'b01, '0, 1'b1, 1'b0);
    step(2'b00, '0, 1'b1, 1'b0);
    for (int p = 0; p < 6; p++) begin
      cr_pct = (p % 2 == 0) ? 15 : 85;
      for (int c = 0; c < 150; c++) begin
        case ($urandom_range(0, 2))
          0: ar = 2'b00;
          1: ar = 2'b01;
          default: ar = 2'b11;
        endcase
        for (int k = 0; k < FU; k++) wv[k] = $urandom_range(0, 99) < 35;
        step(ar, wv, $urandom_range(0, 99) < cr_pct, $urandom_range(0, 59) == 0);
        if (p == 3 && c == 75) rst_cycle();
      end
    end
    step(2'b00, '0, 1'b0, 1'b0);
    @(negedge clk);
    #5;
`ifdef ROB_CTRL_STAT_EN
    chk("stall_cycles", 64'(stall_cycles), 64'(m_stall));
    chk("retired", 64'(retired), 64'(m_retired));
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
